// File: rtl/qrisc32_ifq.sv
// qrisc32 instruction fetch queue: issues word reads to imem over
// req/gnt/rvalid, buffers returned words and feeds decode one per cycle.
// Ports: clk, reset (sync, active-low); imem_req/addr/gnt/rvalid/rdata
// memory side; pipe_stall, jmp_valid/jmp_addr from the pipeline;
// instruction/pc registered to decode; ifq_level = FIFO occupancy.
module qrisc32_ifq #(
   parameter logic [31:0] RESET_PC = 32'h0,
   parameter int unsigned DEPTH    = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   output logic                     imem_req,
   output logic [31:0]              imem_addr,
   input  logic                     imem_gnt,
   input  logic                     imem_rvalid,
   input  logic [31:0]              imem_rdata,
   input  logic                     pipe_stall,
   input  logic                     jmp_valid,
   input  logic [31:0]              jmp_addr,
   output logic [31:0]              instruction,
   output logic [31:0]              pc,
   output logic [$clog2(DEPTH):0]   ifq_level
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW+1:0] CAP = (AW+2)'(DEPTH);

   typedef logic [AW:0] cnt_t;

   logic [31:0]   fetch_pc;
   // Address of the next response that will be kept: requests after a
   // redirect are sequential from the target, so no per-request tag
   // queue is needed.
   logic [31:0]   resp_pc;
   logic [31:0]   word_q [DEPTH];
   logic [31:0]   addr_q [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   cnt_t          count;
   cnt_t          outstanding;
   cnt_t          discard;

   logic [AW+1:0] credit;
   logic          grant;
   logic          push;
   logic          pop;
   cnt_t          out_nxt;
   cnt_t          disc_nxt;

   always_comb begin
      credit    = {1'b0, count} + {1'b0, outstanding};
      imem_req  = reset & ~jmp_valid & (credit < CAP);
      imem_addr = fetch_pc;
      grant     = imem_req & imem_gnt;
      // a response landing in a redirect cycle is wrong-path by definition
      push      = imem_rvalid & (discard == '0) & ~jmp_valid;
      pop       = ~jmp_valid & ~pipe_stall & (count != '0);
      out_nxt   = outstanding + cnt_t'(grant) - cnt_t'(imem_rvalid);
      disc_nxt  = discard - cnt_t'(imem_rvalid && (discard != '0));
   end

   assign ifq_level = count;

   always_ff @(posedge clk) begin
      if (push) begin
         word_q[wr_ptr] <= imem_rdata;
         addr_q[wr_ptr] <= resp_pc;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         fetch_pc    <= RESET_PC;
         resp_pc     <= RESET_PC;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         outstanding <= '0;
         discard     <= '0;
         instruction <= '0;
         pc          <= RESET_PC;
      end else begin
         outstanding <= out_nxt;
         if (jmp_valid) begin
            fetch_pc    <= jmp_addr;
            resp_pc     <= jmp_addr;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            // everything still in flight is now wrong-path
            discard     <= disc_nxt + out_nxt;
            instruction <= '0;
         end else begin
            discard <= disc_nxt;
            if (grant) begin
               fetch_pc <= fetch_pc + 32'd1;
            end
            if (push) begin
               resp_pc <= resp_pc + 32'd1;
               wr_ptr  <= wr_ptr + 1'b1;
            end
            if (pop) begin
               rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + cnt_t'(push) - cnt_t'(pop);
            if (!pipe_stall) begin
               instruction <= pop ? word_q[rd_ptr] : 32'h0;
               if (pop) begin
                  pc <= addr_q[rd_ptr] + 32'd1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_qrisc32_ifq.sv
// Directed bench for qrisc32_ifq with an in-order memory model
// (programmable grant rate and response latency).
module tb_qrisc32_ifq;

   localparam logic [31:0] RPC   = 32'h10;
   localparam int          DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic        pipe_stall = 1'b0;
   logic        jmp_valid = 1'b0;
   logic [31:0] jmp_addr = 32'h0;
   logic [31:0] instruction;
   logic [31:0] pc;
   logic [2:0]  ifq_level;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   qrisc32_ifq #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
      .clk(clk),
      .reset(reset),
      .imem_req(imem_req),
      .imem_addr(imem_addr),
      .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid),
      .imem_rdata(imem_rdata),
      .pipe_stall(pipe_stall),
      .jmp_valid(jmp_valid),
      .jmp_addr(jmp_addr),
      .instruction(instruction),
      .pc(pc),
      .ifq_level(ifq_level)
   );

   logic [31:0] pend_a[$];
   int          pend_r[$];
   int          cyc = 0;
   int          lat = 1;
   int          gnt_pct = 100;
   logic [31:0] exp_addr = RPC;
   logic [31:0] prev_pc = RPC;
   logic [31:0] prev_instr = 32'h0;
   logic        prev_req = 1'b0;
   logic [31:0] prev_addr = 32'h0;
   int          delivered = 0;

   // never zero over the address ranges used, so words differ from bubbles
   function automatic logic [31:0] mem(input logic [31:0] a);
      return {a[30:0], 1'b1};
   endfunction

   task automatic cycle();
      logic        granted;
      logic        resp;
      logic        rst_s;
      logic        jmp_s;
      logic        stall_s;
      logic [31:0] ga;
      logic [31:0] ja;
      int          l;
      #1;
      granted = imem_req & imem_gnt;
      ga      = imem_addr;
      resp    = imem_rvalid;
      rst_s   = reset;
      jmp_s   = jmp_valid;
      stall_s = pipe_stall;
      ja      = jmp_addr;
      if (rst_s && prev_req && !jmp_s) begin
         checks++;
         if (imem_req !== 1'b1 || imem_addr !== prev_addr) begin
            errors++;
            $display("FAIL req_stable: req=%b addr=%h, expected 1/%h",
                     imem_req, imem_addr, prev_addr);
         end
      end
      prev_req  = imem_req & ~imem_gnt;
      prev_addr = imem_addr;
      @(posedge clk);
      cyc++;
      if (!rst_s) begin
         pend_a.delete();
         pend_r.delete();
      end else begin
         if (resp && pend_a.size() > 0) begin
            pend_a.delete(0);
            pend_r.delete(0);
         end
         if (granted) begin
            l = (lat == 0) ? int'($urandom_range(1, 4)) : lat;
            pend_a.push_back(ga);
            pend_r.push_back(cyc + l);
         end
      end
      #1;
      if (rst_s) begin
         checks++;
         if (int'(ifq_level) + pend_a.size() > DEPTH) begin
            errors++;
            $display("FAIL credit: level=%0d inflight=%0d, limit %0d",
                     ifq_level, pend_a.size(), DEPTH);
         end
         checks++;
         if (jmp_s) begin
            if (instruction !== 32'h0 || pc !== prev_pc) begin
               errors++;
               $display("FAIL redirect_out: instr=%h pc=%h, expected 0/%h",
                        instruction, pc, prev_pc);
            end
            exp_addr = ja;
         end else if (stall_s) begin
            if (instruction !== prev_instr || pc !== prev_pc) begin
               errors++;
               $display("FAIL stall_hold: instr=%h pc=%h, expected %h/%h",
                        instruction, pc, prev_instr, prev_pc);
            end
         end else if (instruction !== 32'h0) begin
            if (instruction !== mem(exp_addr) ||
                pc !== exp_addr + 32'd1) begin
               errors++;
               $display("FAIL stream: instr=%h pc=%h, expected %h/%h",
                        instruction, pc, mem(exp_addr),
                        exp_addr + 32'd1);
            end
            exp_addr  = exp_addr + 32'd1;
            delivered++;
         end else if (pc !== prev_pc) begin
            errors++;
            $display("FAIL bubble_pc: pc=%h, expected %h", pc, prev_pc);
         end
      end else begin
         exp_addr = RPC;
      end
      prev_instr = instruction;
      prev_pc    = pc;
      @(negedge clk);
      imem_gnt    = (int'($urandom_range(0, 99)) < gnt_pct);
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
      if (reset && pend_a.size() > 0 && pend_r[0] <= cyc + 1) begin
         imem_rvalid = 1'b1;
         imem_rdata  = mem(pend_a[0]);
      end
   endtask

   task automatic test_reset();
      reset   = 1'b0;
      gnt_pct = 100;
      lat     = 1;
      imem_gnt = 1'b1;
      cycle();
      cycle();
      checks++;
      if (instruction !== 32'h0) begin
         errors++;
         $display("FAIL rst_instr: got %h, expected 0", instruction);
      end
      checks++;
      if (pc !== RPC) begin
         errors++;
         $display("FAIL rst_pc: got %h, expected %h", pc, RPC);
      end
      checks++;
      if (ifq_level !== 3'd0) begin
         errors++;
         $display("FAIL rst_level: got %0d, expected 0", ifq_level);
      end
      checks++;
      if (imem_req !== 1'b0) begin
         errors++;
         $display("FAIL rst_req: got %b, expected 0", imem_req);
      end
      checks++;
      if (imem_addr !== RPC) begin
         errors++;
         $display("FAIL rst_addr: got %h, expected %h", imem_addr, RPC);
      end
      reset = 1'b1;
      #1;
      checks++;
      if (imem_req !== 1'b1) begin
         errors++;
         $display("FAIL first_req: got %b, expected 1", imem_req);
      end
   endtask

   task automatic test_stream();
      logic [31:0] ei[6];
      logic [31:0] ep[6];
      int          d0;
      ei = '{32'h0, 32'h0, 32'h21, 32'h23, 32'h25, 32'h27};
      ep = '{32'h10, 32'h10, 32'h11, 32'h12, 32'h13, 32'h14};
      for (int i = 0; i < 6; i++) begin
         cycle();
         checks++;
         if (instruction !== ei[i] || pc !== ep[i]) begin
            errors++;
            $display("FAIL startup[%0d]: instr=%h pc=%h, expected %h/%h",
                     i, instruction, pc, ei[i], ep[i]);
         end
      end
      d0 = delivered;
      for (int i = 0; i < 20; i++) cycle();
      checks++;
      if (delivered - d0 != 20) begin
         errors++;
         $display("FAIL throughput: got %0d words, expected 20",
                  delivered - d0);
      end
   endtask

   task automatic test_stall();
      int d0;
      pipe_stall = 1'b1;
      for (int i = 0; i < 10; i++) cycle();
      checks++;
      if (ifq_level !== 3'd4) begin
         errors++;
         $display("FAIL stall_level: got %0d, expected 4", ifq_level);
      end
      checks++;
      if (imem_req !== 1'b0) begin
         errors++;
         $display("FAIL stall_req: got %b, expected 0", imem_req);
      end
      pipe_stall = 1'b0;
      d0 = delivered;
      for (int i = 0; i < 10; i++) cycle();
      checks++;
      if (delivered - d0 != 10) begin
         errors++;
         $display("FAIL stall_release: got %0d words, expected 10",
                  delivered - d0);
      end
   endtask

   task automatic test_redirect();
      int n;
      lat = 3;
      for (int i = 0; i < 12; i++) cycle();
      n = 0;
      while (pend_a.size() != 3 && n < 20) begin
         cycle();
         n++;
      end
      checks++;
      if (pend_a.size() != 3) begin
         errors++;
         $display("FAIL inflight: got %0d, expected 3", pend_a.size());
      end
      jmp_valid = 1'b1;
      jmp_addr  = 32'h100;
      cycle();
      jmp_valid = 1'b0;
      checks++;
      if (instruction !== 32'h0) begin
         errors++;
         $display("FAIL jmp_bubble: got %h, expected 0", instruction);
      end
      n = 0;
      while (instruction === 32'h0 && n < 30) begin
         cycle();
         n++;
      end
      checks++;
      if (instruction !== 32'h201 || pc !== 32'h101) begin
         errors++;
         $display("FAIL jmp_target: instr=%h pc=%h, expected 201/101",
                  instruction, pc);
      end
   endtask

   task automatic test_coincident();
      int n;
      lat = 1;
      for (int i = 0; i < 8; i++) cycle();
      pipe_stall = 1'b1;
      n = 0;
      while (imem_rvalid !== 1'b1 && n < 10) begin
         cycle();
         n++;
      end
      checks++;
      if (imem_rvalid !== 1'b1) begin
         errors++;
         $display("FAIL co_rvalid: got %b, expected 1", imem_rvalid);
      end
      jmp_valid = 1'b1;
      jmp_addr  = 32'h200;
      cycle();
      jmp_valid = 1'b0;
      checks++;
      if (instruction !== 32'h0) begin
         errors++;
         $display("FAIL co_instr: got %h, expected 0", instruction);
      end
      checks++;
      if (ifq_level !== 3'd0) begin
         errors++;
         $display("FAIL co_level: got %0d, expected 0", ifq_level);
      end
      pipe_stall = 1'b0;
      n = 0;
      while (instruction === 32'h0 && n < 20) begin
         cycle();
         n++;
      end
      checks++;
      if (instruction !== 32'h401 || pc !== 32'h201) begin
         errors++;
         $display("FAIL co_target: instr=%h pc=%h, expected 401/201",
                  instruction, pc);
      end
   endtask

   task automatic test_random();
      int d0;
      lat     = 0;
      gnt_pct = 50;
      d0      = delivered;
      for (int i = 0; i < 300; i++) begin
         pipe_stall = ($urandom_range(0, 4) == 0);
         cycle();
      end
      pipe_stall = 1'b0;
      checks++;
      if (delivered - d0 < 40) begin
         errors++;
         $display("FAIL rand_progress: got %0d words, expected >= 40",
                  delivered - d0);
      end
      lat     = 1;
      gnt_pct = 100;
      for (int i = 0; i < 6; i++) cycle();
   endtask

   task automatic test_wrap_reset();
      logic [31:0] gi[3];
      logic [31:0] gp[3];
      logic [31:0] wi[3];
      logic [31:0] wp[3];
      int          k;
      int          n;
      wi = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h0000_0001};
      wp = '{32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
      gi = '{32'h0, 32'h0, 32'h0};
      gp = '{32'h0, 32'h0, 32'h0};
      jmp_valid = 1'b1;
      jmp_addr  = 32'hFFFF_FFFE;
      cycle();
      jmp_valid = 1'b0;
      k = 0;
      n = 0;
      while (k < 3 && n < 40) begin
         cycle();
         n++;
         if (instruction !== 32'h0) begin
            gi[k] = instruction;
            gp[k] = pc;
            k++;
         end
      end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (gi[i] !== wi[i] || gp[i] !== wp[i]) begin
            errors++;
            $display("FAIL wrap[%0d]: instr=%h pc=%h, expected %h/%h",
                     i, gi[i], gp[i], wi[i], wp[i]);
         end
      end
      reset = 1'b0;
      cycle();
      checks++;
      if (instruction !== 32'h0 || pc !== RPC || ifq_level !== 3'd0) begin
         errors++;
         $display("FAIL mid_reset: instr=%h pc=%h lvl=%0d, expected 0/%h/0",
                  instruction, pc, ifq_level, RPC);
      end
      checks++;
      if (imem_req !== 1'b0 || imem_addr !== RPC) begin
         errors++;
         $display("FAIL mid_reset_req: req=%b addr=%h, expected 0/%h",
                  imem_req, imem_addr, RPC);
      end
      reset = 1'b1;
      n = 0;
      while (instruction === 32'h0 && n < 20) begin
         cycle();
         n++;
      end
      checks++;
      if (instruction !== 32'h21 || pc !== 32'h11) begin
         errors++;
         $display("FAIL restart: instr=%h pc=%h, expected 21/11",
                  instruction, pc);
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_stream();
      test_stall();
      test_redirect();
      test_coincident();
      test_random();
      test_wrap_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
